// File: rtl/pipelined_addsub_pkg.sv
// Shared helpers for the pipelined adder/subtractor.
// Signed overflow follows the operand and result sign bits.
package pipelined_addsub_pkg;

   function automatic logic ovf_f(
      input logic a_msb,
      input logic b_msb,
      input logic s_msb
   );
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational ripple-carry slice of CHUNK bits.
// One slice per pipeline stage.
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK:0] w_c;

   always_comb begin
      w_c    = '0;
      s      = '0;
      w_c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]     = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = w_c[CHUNK];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry add/sub, one CHUNK per stage,
// with valid/ready flow control on both sides.
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH ||
       (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_addsub: illegal WIDTH/STAGES");
   end

   logic             r_vld [STAGES];
   logic             r_cy  [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];

   logic             w_rdy [STAGES+1];
   logic             w_uv  [STAGES];
   logic             w_pc  [STAGES];
   logic [WIDTH-1:0] w_pa  [STAGES];
   logic [WIDTH-1:0] w_pb  [STAGES];
   logic [WIDTH-1:0] w_ps  [STAGES];
   logic [WIDTH-1:0] w_ns  [STAGES];
   logic [CHUNK-1:0] w_s   [STAGES];
   logic             w_co  [STAGES];

   // Stage 0 sees the raw beat with B pre-inverted for subtract.
   always_comb begin
      w_uv[0] = in_valid;
      w_pa[0] = in_a;
      w_pb[0] = in_sub ? ~in_b : in_b;
      w_ps[0] = '0;
      w_pc[0] = in_sub | in_cin;
      for (int k = 1; k < STAGES; k++) begin
         w_uv[k] = r_vld[k-1];
         w_pa[k] = r_a[k-1];
         w_pb[k] = r_b[k-1];
         w_ps[k] = r_sum[k-1];
         w_pc[k] = r_cy[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k <= STAGES; k++) begin
         w_rdy[k] = out_ready;
      end
      for (int k = LAST; k >= 0; k--) begin
         w_rdy[k] = !r_vld[k] || w_rdy[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      addsub_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a    (w_pa[k][k*CHUNK +: CHUNK]),
         .b    (w_pb[k][k*CHUNK +: CHUNK]),
         .cin  (w_pc[k]),
         .s    (w_s[k]),
         .cout (w_co[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         w_ns[k] = w_ps[k];
         w_ns[k][k*CHUNK +: CHUNK] = w_s[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_cy[k]  <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_vld[k] <= w_uv[k];
               if (w_uv[k]) begin
                  r_a[k]   <= w_pa[k];
                  r_b[k]   <= w_pb[k];
                  r_sum[k] <= w_ns[k];
                  r_cy[k]  <= w_co[k];
               end
            end
         end
      end
   end

   assign in_ready  = w_rdy[0];
   assign out_valid = r_vld[LAST];
   assign out_sum   = r_sum[LAST];
   assign out_cout  = r_cy[LAST];
   assign out_ovf   = ovf_f(r_a[LAST][WIDTH-1],
                            r_b[LAST][WIDTH-1],
                            r_sum[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and randomized bench for pipelined_addsub
// over four WIDTH/STAGES configurations.
module tb_pipelined_addsub;

   localparam int N = 1000;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] t_a;
   logic [31:0] t_b;
   logic        in_cin;
   logic        in_sub;

   logic        rdy16, vld16, co16, ov16;
   logic [15:0] sum16;
   logic        rdy81, vld81, co81, ov81;
   logic [7:0]  sum81;
   logic        rdy88, vld88, co88, ov88;
   logic [7:0]  sum88;
   logic        rdy32, vld32, co32, ov32;
   logic [31:0] sum32;

   int          nchecks;
   int          nfail;

   logic [31:0] ha [N];
   logic [31:0] hb [N];
   logic        hc [N];
   logic        hs [N];

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_d16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy16),
      .in_a(t_a[15:0]), .in_b(t_b[15:0]),
      .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(vld16), .out_ready(out_ready),
      .out_sum(sum16), .out_cout(co16), .out_ovf(ov16)
   );

   pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_d81 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy81),
      .in_a(t_a[7:0]), .in_b(t_b[7:0]),
      .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(vld81), .out_ready(out_ready),
      .out_sum(sum81), .out_cout(co81), .out_ovf(ov81)
   );

   pipelined_addsub #(.WIDTH(8), .STAGES(8)) u_d88 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy88),
      .in_a(t_a[7:0]), .in_b(t_b[7:0]),
      .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(vld88), .out_ready(out_ready),
      .out_sum(sum88), .out_cout(co88), .out_ovf(ov88)
   );

   pipelined_addsub #(.WIDTH(32), .STAGES(2)) u_d32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy32),
      .in_a(t_a), .in_b(t_b),
      .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(vld32), .out_ready(out_ready),
      .out_sum(sum32), .out_cout(co32), .out_ovf(ov32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // Plain-arithmetic model: {ovf, cout, sum zero-extended to 32}.
   function automatic logic [33:0] ref_f(
      input int w, input logic [31:0] a, input logic [31:0] b,
      input logic cin, input logic sub);
      logic [63:0] m, am, bm, full;
      logic        sa, sb, ss;
      m    = (64'd1 << w) - 64'd1;
      am   = {32'b0, a} & m;
      bm   = sub ? (~{32'b0, b}) & m : {32'b0, b} & m;
      full = am + bm + (sub ? 64'd1 : {63'b0, cin});
      sa   = am[w-1];
      sb   = bm[w-1];
      ss   = full[w-1];
      return {(sa == sb) && (ss != sa), full[w], full[31:0] & m[31:0]};
   endfunction

   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8080_8080;
         3:       return 32'h7F7F_7F7F;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic one_beat(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic cin,
                           input logic sub, input logic [15:0] es,
                           input logic ec, input logic eo);
      t_a = {16'b0, a};
      t_b = {16'b0, b};
      in_cin = cin;
      in_sub = sub;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, rdy16, 1);
      tick();
      in_valid = 1'b0;
      t_a = $urandom;
      t_b = $urandom;
      for (int j = 1; j < 4; j++) begin
         chk({tag, "_early"}, vld16, 0);
         tick();
      end
      chk(tag, {vld16, sum16, co16, ov16}, {1'b1, es, ec, eo});
      tick();
      chk({tag, "_dup"}, vld16, 0);
   endtask

   task automatic chk_dut(input string tag, input int w, input int s,
                          input int i, input logic vld, input logic ov,
                          input logic co, input logic [31:0] sm);
      int j;
      if (i >= s - 1) begin
         j = i - (s - 1);
         chk(tag, {vld, ov, co, sm},
             {1'b1, ref_f(w, ha[j], hb[j], hc[j], hs[j])});
      end else begin
         chk({tag, "_fill"}, vld, 0);
      end
   endtask

   initial begin
      int          nb, got, cyc;
      logic        have_hold;
      logic [15:0] hold;

      nchecks = 0;
      nfail = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      t_a = '0;
      t_b = '0;
      in_cin = 1'b0;
      in_sub = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      chk("idle", {vld16, sum16, co16, ov16, rdy16}, {1'b0, 16'h0, 3'b001});

      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         t_a = $urandom;
         t_b = $urandom;
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {vld16, sum16}, 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("flush", {vld16, sum16, rdy16}, {1'b0, 16'h0, 1'b1});
      end

      one_beat("add_carry", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
      one_beat("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
      one_beat("sub_neg", 16'h0003, 16'h0005, 0, 1, 16'hFFFE, 0, 0);
      one_beat("wrap_cin", 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0);
      one_beat("sub_cin", 16'h0003, 16'h0005, 1, 1, 16'hFFFE, 0, 0);
      one_beat("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);

      nb = 0;
      got = 0;
      cyc = 0;
      have_hold = 1'b0;
      hold = '0;
      in_cin = 1'b0;
      in_sub = 1'b0;
      while (got < 8 && cyc < 64) begin
         out_ready = !(cyc >= 2 && cyc <= 7);
         in_valid = (nb < 8);
         if (cyc >= 4 && cyc <= 7) begin
            t_a = $urandom;
            t_b = $urandom;
         end else begin
            t_a = 32'(nb + 1);
            t_b = 32'(3 * (nb + 1));
         end
         #1;
         if (cyc == 7) begin
            chk("bp_inrdy", rdy16, 0);
            chk("bp_taken", 32'(nb), 4);
         end
         if (vld16 && !out_ready) begin
            if (have_hold) chk("bp_hold", sum16, hold);
            hold = sum16;
            have_hold = 1'b1;
         end else begin
            have_hold = 1'b0;
         end
         if (vld16 && out_ready) begin
            chk("bp_order", sum16, 16'(4 * (got + 1)));
            got++;
         end
         if (in_valid && rdy16) nb++;
         tick();
         cyc++;
      end
      chk("bp_count", 32'(got), 8);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_extra", vld16, 0);
      end

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
         ha[i] = rnd();
         hb[i] = rnd();
         hc[i] = 1'($urandom_range(0, 1));
         hs[i] = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         out_ready = 1'b1;
         t_a = ha[i];
         t_b = hb[i];
         in_cin = hc[i];
         in_sub = hs[i];
         #1;
         chk("tp_rdy", {rdy16, rdy81, rdy88, rdy32}, 4'hF);
         tick();
         chk_dut("r16_4", 16, 4, i, vld16, ov16, co16, {16'b0, sum16});
         chk_dut("r8_1", 8, 1, i, vld81, ov81, co81, {24'b0, sum81});
         chk_dut("r8_8", 8, 8, i, vld88, ov88, co88, {24'b0, sum88});
         chk_dut("r32_2", 32, 2, i, vld32, ov32, co32, sum32);
      end
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule
